opl3_host_if: RTL and testbench
===============================

# opl3_host_if

Host-side write interface for the OPL3 core. Decodes the CPU's four-port OPL3 I/O window into latched register addresses and data writes, then buffers them. It emits them to the register file as `opl3_reg_wr_t` pulses, spaced by a fixed minimum interval. It sits between the SoC sound bus decoder and the OPL3 register file, and it also returns the status byte on reads.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: write-buffer entries; power of two, ≥2.
- `WR_SPACING`, 32: minimum clocks between successive `opl3_reg_wr.valid` pulses; ≥2.

Ports:
- `clk` in 1: core clock, 24.576 MHz.
- `reset` in 1: synchronous, active-high.
- `cpu_wr` in 1: one-cycle write strobe.
- `cpu_rd` in 1: one-cycle read strobe.
- `cpu_addr` in 2: port select; 0 = addr bank0, 1 = data, 2 = addr bank1, 3 = data.
- `cpu_din` in 8: write data.
- `cpu_dout` out 8: registered read data.
- `status_flags` in 3: {irq, ft1, ft2} from the timer block.
- `cpu_busy` out 1: buffer full.
- `wr_overflow` out 1: sticky; set when a write was dropped.
- `opl3_reg_wr` out `opl3_reg_wr_t`: {valid, bank_num, address, data} to the register file.

## Operation
- Address write (`cpu_addr` 0 or 2): latch `cpu_din` into `addr_q`; latch `bank_q` as 0 or 1. No buffer push.
- Data write (`cpu_addr` 1 or 3): push {`bank_q`, `addr_q`, `cpu_din`}.
  - Bank comes from the last address write, not from the data port used.
  - `addr_q` and `bank_q` are unchanged, so repeated data writes reuse the address.
- Push while full, with no pop in the same cycle: entry dropped; `wr_overflow` set until reset.
- Read with `cpu_addr` = 0: `cpu_dout` = {irq, ft1, ft2, 5'b0}, registered the cycle after `cpu_rd`. Any other address returns 8'hFF.
- `cpu_dout` holds its value between reads.
- Drain FSM:
  - IDLE: if buffer not empty, pop and go to EMIT.
  - EMIT: `opl3_reg_wr` = popped entry with valid=1 for exactly one cycle. Load gap counter with `WR_SPACING`-2, go to GAP.
  - GAP: decrement the counter; at 0 go to IDLE.
  - Consecutive valid pulses are therefore exactly `WR_SPACING` clocks apart when the buffer stays non-empty.
- When valid=0, the other `opl3_reg_wr` fields hold their last values.
- `cpu_busy` = count == `FIFO_DEPTH`, combinational from the registered count.
- `cpu_wr` and `cpu_rd` in the same cycle: both are serviced independently.

## Timing
- Reset values:
  - `addr_q` = 0, `bank_q` = 0
  - buffer empty, count 0
  - FSM in IDLE, gap counter 0
  - `opl3_reg_wr` all zero
  - `cpu_dout` = 8'hFF
  - `cpu_busy` = 0, `wr_overflow` = 0
- Latency: a data write strobe in cycle N gives `opl3_reg_wr.valid` high in cycle N+2 when the FSM is idle and the buffer is empty.
- Simultaneous push and pop when full: the pop frees a slot and the push is accepted. No overflow, count unchanged.
- Pointers wrap modulo `FIFO_DEPTH`. Count width is clog2(`FIFO_DEPTH`)+1.
- Reset mid-GAP or mid-EMIT: valid drops in the next cycle and buffered entries are discarded.

## Configuration
- `OPL3_HOST_FIFO_EN` defined: buffer is `FIFO_DEPTH` entries.
- Undefined: buffer is one holding register and `FIFO_DEPTH` is ignored.
  - `cpu_busy` is high from accept until that entry's EMIT cycle.
  - A data write while busy is dropped and sets `wr_overflow`.
  - Same-cycle pop and push is accepted, as above.

## Structure
- In `opl3_pkg`:
  - `HOST_WR_SPACING` default.
  - `typedef enum logic [1:0] {HOST_ADDR0, HOST_DATA0, HOST_ADDR1, HOST_DATA1} host_port_t`.
  - Status bit positions `STATUS_IRQ_BIT` = 7, `STATUS_FT1_BIT` = 6, `STATUS_FT2_BIT` = 5.
  - Reuse the existing `opl3_reg_wr_t`.
- One sub-module, `opl3_wr_fifo`: synchronous FIFO with push/pop/full/empty/count, generated only under `OPL3_HOST_FIFO_EN`.

## Test plan
- Write port0 = 8'hA0, then port1 = 8'h41. Expect one valid pulse {bank 0, addr 8'hA0, data 8'h41} exactly 2 cycles after the data strobe.
- Write port2 = 8'h05, then port1 = 8'h01. Expect bank_num = 1, address 8'h05, data 8'h01.
- Back-to-back data writes 8'h10, 8'h11, 8'h12 on one address. Expect three pulses in order, `WR_SPACING` clocks apart, same address.
- Six data writes in consecutive cycles with `FIFO_DEPTH` = 4:
  - `cpu_busy` asserts.
  - `wr_overflow` = 1.
  - The first five values are emitted (one was popped during the burst); the sixth is missing.
- With `status_flags` = 3'b101, pulse `cpu_rd` on port 0, then on port 1. Expect `cpu_dout` = 8'hA0, then 8'hFF.
- Assert `reset` during GAP with 2 entries pending. Expect valid low, count 0, and no further pulses after reset releases.

Source files
------------

// File: rtl/opl3_pkg.sv
// Shared types and constants for the OPL3 core: register-file write bus,
// host port decode and status byte layout.
package opl3_pkg;

   localparam int HOST_WR_SPACING = 32;
   localparam int HOST_FIFO_DEPTH = 4;

   localparam int STATUS_IRQ_BIT = 7;
   localparam int STATUS_FT1_BIT = 6;
   localparam int STATUS_FT2_BIT = 5;

   typedef enum logic [1:0] {
      HOST_ADDR0,
      HOST_DATA0,
      HOST_ADDR1,
      HOST_DATA1
   } host_port_t;

   typedef struct packed {
      logic       valid;
      logic       bank_num;
      logic [7:0] address;
      logic [7:0] data;
   } opl3_reg_wr_t;

   // One buffered register write, waiting to be drained to the register file.
   typedef struct packed {
      logic       bank_num;
      logic [7:0] address;
      logic [7:0] data;
   } host_wr_entry_t;

   typedef enum logic [1:0] {
      DRAIN_IDLE,
      DRAIN_EMIT,
      DRAIN_GAP
   } drain_state_t;

   // flags = {irq, ft1, ft2}; remaining bits read as zero.
   function automatic logic [7:0] status_byte(input logic [2:0] flags);
      logic [7:0] b;
      b                 = 8'h00;
      b[STATUS_IRQ_BIT] = flags[2];
      b[STATUS_FT1_BIT] = flags[1];
      b[STATUS_FT2_BIT] = flags[0];
      return b;
   endfunction

endpackage

// File: rtl/opl3_wr_fifo.sv
// Synchronous FIFO for buffered host register writes. DEPTH must be a power
// of two so the pointers wrap naturally. A push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module opl3_wr_fifo
   import opl3_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           push,
   input  host_wr_entry_t push_data,
   input  logic           pop,
   output host_wr_entry_t pop_data,
   output logic           full,
   output logic           empty,
   output logic [CW-1:0]  count
);

   localparam int AW = $clog2(DEPTH);

   host_wr_entry_t mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic           push_ok;
   logic           pop_ok;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign pop_ok   = pop && !empty;
   assign push_ok  = push && (!full || pop_ok);
   assign pop_data = mem[rd_ptr];

   // Entry storage; no reset needed since count gates every read.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/opl3_host_if.sv
// Host-side write interface for the OPL3 core. Decodes the four-port CPU
// window into address latches and buffered data writes, drains the buffer to
// the register file with a fixed minimum spacing, and returns the status byte.
// Build option OPL3_HOST_FIFO_EN: when defined the write buffer is a
// FIFO_DEPTH-entry FIFO; otherwise it is a single holding register.
//
// Drain FSM
//   state      | meaning
//   DRAIN_IDLE | waiting; pops the buffer as soon as it is non-empty
//   DRAIN_EMIT | opl3_reg_wr.valid high for this one cycle; loads gap counter
//   DRAIN_GAP  | counting down so pulses are WR_SPACING clocks apart
module opl3_host_if
   import opl3_pkg::*;
#(
   parameter int FIFO_DEPTH = HOST_FIFO_DEPTH,
   parameter int WR_SPACING = HOST_WR_SPACING
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cpu_wr,
   input  logic         cpu_rd,
   input  logic [1:0]   cpu_addr,
   input  logic [7:0]   cpu_din,
   output logic [7:0]   cpu_dout,
   input  logic [2:0]   status_flags,
   output logic         cpu_busy,
   output logic         wr_overflow,
   output opl3_reg_wr_t opl3_reg_wr
);

   if (WR_SPACING < 2) begin : g_bad_spacing
      $error("opl3_host_if: WR_SPACING must be at least 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("opl3_host_if: FIFO_DEPTH must be a power of two, at least 2");
   end

   // Gap counter starts at WR_SPACING-2 and leaves GAP on the 1->0 step, so
   // EMIT + GAP + IDLE spans exactly WR_SPACING clocks.
   localparam int             GW       = $clog2(WR_SPACING);
   localparam logic [GW-1:0]  GAP_LOAD = GW'(WR_SPACING - 2);

   host_port_t     port;
   logic           addr_wr;
   logic           data_wr;
   logic [7:0]     addr_q;
   logic           bank_q;
   host_wr_entry_t push_entry;
   host_wr_entry_t pop_entry;
   logic           buf_pop;
   logic           buf_full;
   logic           buf_empty;
   drain_state_t   state;
   drain_state_t   state_next;
   logic [GW-1:0]  gap_cnt;
   logic [GW-1:0]  gap_next;

   assign port       = host_port_t'(cpu_addr);
   assign addr_wr    = cpu_wr && (port == HOST_ADDR0 || port == HOST_ADDR1);
   assign data_wr    = cpu_wr && (port == HOST_DATA0 || port == HOST_DATA1);
   assign push_entry = '{bank_num: bank_q, address: addr_q, data: cpu_din};

`ifdef OPL3_HOST_FIFO_EN
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   logic [CW-1:0] buf_count;

   opl3_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (data_wr),
      .push_data (push_entry),
      .pop       (buf_pop),
      .pop_data  (pop_entry),
      .full      (buf_full),
      .empty     (buf_empty),
      .count     (buf_count)
   );

   assign cpu_busy = (buf_count == CW'(FIFO_DEPTH));
`else
   logic           hold_valid;
   host_wr_entry_t hold_entry;

   // Single holding register; a same-cycle pop frees it for the new push.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_valid <= 1'b0;
         hold_entry <= '0;
      end else if (data_wr && (!hold_valid || buf_pop)) begin
         hold_valid <= 1'b1;
         hold_entry <= push_entry;
      end else if (buf_pop) begin
         hold_valid <= 1'b0;
      end
   end

   assign pop_entry = hold_entry;
   assign buf_full  = hold_valid;
   assign buf_empty = !hold_valid;
   assign cpu_busy  = hold_valid;
`endif

   // Address port latches; data writes leave them untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q <= 8'h00;
         bank_q <= 1'b0;
      end else if (addr_wr) begin
         addr_q <= cpu_din;
         bank_q <= (port == HOST_ADDR1);
      end
   end

   // Sticky drop flag: a push into a full buffer with no freeing pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_overflow <= 1'b0;
      end else if (data_wr && buf_full && !buf_pop) begin
         wr_overflow <= 1'b1;
      end
   end

   // Registered read port; holds its value between reads.
   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_dout <= 8'hFF;
      end else if (cpu_rd) begin
         cpu_dout <= (port == HOST_ADDR0) ? status_byte(status_flags) : 8'hFF;
      end
   end

   // Drain FSM state and gap counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= DRAIN_IDLE;
         gap_cnt <= '0;
      end else begin
         state   <= state_next;
         gap_cnt <= gap_next;
      end
   end

   // Drain FSM next-state and pop decision.
   always_comb begin
      state_next = state;
      gap_next   = gap_cnt;
      buf_pop    = 1'b0;
      case (state)
         DRAIN_IDLE: begin
            if (!buf_empty) begin
               buf_pop    = 1'b1;
               state_next = DRAIN_EMIT;
            end
         end
         DRAIN_EMIT: begin
            gap_next   = GAP_LOAD;
            state_next = (GAP_LOAD == '0) ? DRAIN_IDLE : DRAIN_GAP;
         end
         DRAIN_GAP: begin
            gap_next = gap_cnt - 1'b1;
            if (gap_cnt == GW'(1) || gap_cnt == '0) begin
               gap_next   = '0;
               state_next = DRAIN_IDLE;
            end
         end
         default: state_next = DRAIN_IDLE;
      endcase
   end

   // Register-file write port: popped entry appears in EMIT; fields hold after.
   always_ff @(posedge clk) begin
      if (reset) begin
         opl3_reg_wr <= '0;
      end else if (buf_pop) begin
         opl3_reg_wr <= '{valid:    1'b1,
                          bank_num: pop_entry.bank_num,
                          address:  pop_entry.address,
                          data:     pop_entry.data};
      end else begin
         opl3_reg_wr.valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_opl3_host_if.sv
// Self-checking bench for opl3_host_if. Expected register writes go into a
// scoreboard queue when the CPU write is driven; a monitor logs every valid
// pulse and the test tasks pop and compare them.
module tb_opl3_host_if;
   import opl3_pkg::*;

   localparam int DEPTH = 4;
   localparam int SPC   = 8;
`ifdef OPL3_HOST_FIFO_EN
   localparam int CAP = DEPTH;
`else
   localparam int CAP = 1;
`endif

   typedef struct {
      logic       bank;
      logic [7:0] addr;
      logic [7:0] data;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         cpu_wr = 1'b0;
   logic         cpu_rd = 1'b0;
   logic [1:0]   cpu_addr = 2'd0;
   logic [7:0]   cpu_din = 8'h00;
   logic [7:0]   cpu_dout;
   logic [2:0]   status_flags = 3'b000;
   logic         cpu_busy;
   logic         wr_overflow;
   opl3_reg_wr_t opl3_reg_wr;

   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t exp_q[$];

   int         pw = 0;
   int         pr = 0;
   int         p_cyc  [256];
   logic       p_bank [256];
   logic [7:0] p_addr [256];
   logic [7:0] p_data [256];
   int         last_wr_cyc;
   int         first_idx;

   opl3_host_if #(.FIFO_DEPTH(DEPTH), .WR_SPACING(SPC)) dut (
      .clk          (clk),
      .reset        (reset),
      .cpu_wr       (cpu_wr),
      .cpu_rd       (cpu_rd),
      .cpu_addr     (cpu_addr),
      .cpu_din      (cpu_din),
      .cpu_dout     (cpu_dout),
      .status_flags (status_flags),
      .cpu_busy     (cpu_busy),
      .wr_overflow  (wr_overflow),
      .opl3_reg_wr  (opl3_reg_wr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (opl3_reg_wr.valid === 1'b1 && pw < 256) begin
         p_cyc[pw]  = cyc;
         p_bank[pw] = opl3_reg_wr.bank_num;
         p_addr[pw] = opl3_reg_wr.address;
         p_data[pw] = opl3_reg_wr.data;
         pw = pw + 1;
      end
   end

   task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      cpu_wr      = 1'b1;
      cpu_addr    = a;
      cpu_din     = d;
      last_wr_cyc = cyc;
      @(negedge clk);
      cpu_wr = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Wait (bounded) for n pulses and compare each against the scoreboard.
   task automatic take_pulses(input int n, input int budget, input string name);
      int   k;
      exp_t e;
      k = 0;
      while ((pw - pr) < n && k < budget) begin
         @(negedge clk);
         #1;
         k++;
      end
      vectors++;
      if ((pw - pr) < n) begin
         miscompares++;
         $display("FAIL %s timeout: got %0d pulses, need %0d", name, pw - pr, n);
      end
      first_idx = pr;
      while (n > 0 && pr < pw) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s unexpected pulse: bank %0d addr %h data %h, none expected",
                     name, p_bank[pr], p_addr[pr], p_data[pr]);
         end else begin
            e = exp_q.pop_front();
            if (p_bank[pr] !== e.bank || p_addr[pr] !== e.addr || p_data[pr] !== e.data) begin
               miscompares++;
               $display("FAIL %s pulse: got bank %0d addr %h data %h, want bank %0d addr %h data %h",
                        name, p_bank[pr], p_addr[pr], p_data[pr], e.bank, e.addr, e.data);
            end
         end
         pr++;
         n--;
      end
   endtask

   task automatic check_quiet(input int n, input string name);
      idle(n);
      #1;
      vectors++;
      if (pw != pr) begin
         miscompares++;
         $display("FAIL %s extra pulses: got %0d, want 0", name, pw - pr);
         pr = pw;
      end
   endtask

   task automatic check_spacing(input int n, input string name);
      for (int i = 0; i + 1 < n; i++) begin
         vectors++;
         if (p_cyc[first_idx + i + 1] - p_cyc[first_idx + i] != SPC) begin
            miscompares++;
            $display("FAIL %s spacing %0d: got %0d clocks, want %0d", name, i,
                     p_cyc[first_idx + i + 1] - p_cyc[first_idx + i], SPC);
         end
      end
   endtask

   task automatic test_reset;
      idle(2);
      vectors++;
      if (opl3_reg_wr !== '0) begin
         miscompares++;
         $display("FAIL reset_reg_wr: got %h, want 0", opl3_reg_wr);
      end
      reset = 1'b0;
      idle(2);
      vectors++;
      if (cpu_dout !== 8'hFF) begin
         miscompares++;
         $display("FAIL reset_dout: got %h, want ff", cpu_dout);
      end
      vectors++;
      if (cpu_busy !== 1'b0 || wr_overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got busy %b ovf %b, want 0 0", cpu_busy, wr_overflow);
      end
      vectors++;
      if (opl3_reg_wr.valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_valid: got %b, want 0", opl3_reg_wr.valid);
      end
   endtask

   task automatic test_single_write;
      int wc;
      cpu_write(2'd0, 8'hA0);
      exp_q.push_back('{bank: 1'b0, addr: 8'hA0, data: 8'h41});
      cpu_write(2'd1, 8'h41);
      wc = last_wr_cyc;
      take_pulses(1, 20, "single");
      vectors++;
      if (p_cyc[first_idx] != wc + 2) begin
         miscompares++;
         $display("FAIL single_latency: got %0d cycles, want 2", p_cyc[first_idx] - wc);
      end
      check_quiet(SPC + 4, "single_quiet");
   endtask

   task automatic test_bank1;
      cpu_write(2'd2, 8'h05);
      exp_q.push_back('{bank: 1'b1, addr: 8'h05, data: 8'h01});
      cpu_write(2'd1, 8'h01);
      take_pulses(1, 20, "bank1");
      check_quiet(SPC + 4, "bank1_quiet");
   endtask

   task automatic test_status_read;
      status_flags = 3'b101;
      @(negedge clk);
      cpu_rd = 1'b1; cpu_addr = 2'd0;
      @(negedge clk);
      cpu_rd = 1'b0;
      vectors++;
      if (cpu_dout !== 8'hA0) begin
         miscompares++;
         $display("FAIL status_port0: got %h, want a0", cpu_dout);
      end
      status_flags = 3'b010;
      idle(3);
      vectors++;
      if (cpu_dout !== 8'hA0) begin
         miscompares++;
         $display("FAIL status_hold: got %h, want a0", cpu_dout);
      end
      cpu_rd = 1'b1; cpu_addr = 2'd1;
      @(negedge clk);
      cpu_rd = 1'b0;
      vectors++;
      if (cpu_dout !== 8'hFF) begin
         miscompares++;
         $display("FAIL status_port1: got %h, want ff", cpu_dout);
      end
      cpu_rd = 1'b1; cpu_addr = 2'd0;
      @(negedge clk);
      cpu_rd = 1'b0;
      vectors++;
      if (cpu_dout !== 8'h40) begin
         miscompares++;
         $display("FAIL status_ft1: got %h, want 40", cpu_dout);
      end
   endtask

   task automatic test_back_to_back;
      int k;
      cpu_write(2'd0, 8'h60);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         cpu_wr = 1'b0;
         k = 0;
         while (cpu_busy === 1'b1 && k < 4 * SPC) begin
            @(negedge clk);
            k++;
         end
         cpu_wr   = 1'b1;
         cpu_addr = 2'd3;
         cpu_din  = 8'h10 + 8'(i);
         exp_q.push_back('{bank: 1'b0, addr: 8'h60, data: 8'h10 + 8'(i)});
      end
      @(negedge clk);
      cpu_wr = 1'b0;
      take_pulses(3, 6 * SPC, "b2b");
      check_spacing(3, "b2b");
      check_quiet(SPC + 4, "b2b_quiet");
   endtask

   task automatic test_burst_overflow;
      logic busy_seen;
      busy_seen = 1'b0;
      cpu_write(2'd0, 8'h70);
      vectors++;
      if (wr_overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL burst_pre_ovf: got %b, want 0", wr_overflow);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         busy_seen = busy_seen | (cpu_busy === 1'b1);
         cpu_wr   = 1'b1;
         cpu_addr = 2'd1;
         cpu_din  = 8'h20 + 8'(i);
         if (i < CAP + 1) exp_q.push_back('{bank: 1'b0, addr: 8'h70, data: 8'h20 + 8'(i)});
      end
      @(negedge clk);
      busy_seen = busy_seen | (cpu_busy === 1'b1);
      cpu_wr = 1'b0;
      vectors++;
      if (busy_seen !== 1'b1) begin
         miscompares++;
         $display("FAIL burst_busy: got %b, want 1", busy_seen);
      end
      vectors++;
      if (wr_overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL burst_ovf: got %b, want 1", wr_overflow);
      end
      take_pulses(CAP + 1, (CAP + 3) * SPC, "burst");
      check_spacing(CAP + 1, "burst");
      check_quiet(2 * SPC + 5, "burst_sixth");
      vectors++;
      if (wr_overflow !== 1'b1 || cpu_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL burst_after: got ovf %b busy %b, want 1 0", wr_overflow, cpu_busy);
      end
   endtask

   task automatic test_reset_in_gap;
      cpu_write(2'd2, 8'h33);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         cpu_wr   = 1'b1;
         cpu_addr = 2'd1;
         cpu_din  = 8'h30 + 8'(i);
         if (i == 0) exp_q.push_back('{bank: 1'b1, addr: 8'h33, data: 8'h30});
      end
      @(negedge clk);
      cpu_wr = 1'b0;
      take_pulses(1, 20, "rst_gap_first");
      idle(2);
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      exp_q.delete();
      vectors++;
      if (opl3_reg_wr !== '0) begin
         miscompares++;
         $display("FAIL rst_gap_reg_wr: got %h, want 0", opl3_reg_wr);
      end
      vectors++;
      if (cpu_busy !== 1'b0 || wr_overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_gap_flags: got busy %b ovf %b, want 0 0", cpu_busy, wr_overflow);
      end
      check_quiet(4 * SPC, "rst_gap_drain");
      exp_q.push_back('{bank: 1'b0, addr: 8'h00, data: 8'h55});
      cpu_write(2'd3, 8'h55);
      take_pulses(1, 20, "rst_gap_addr_cleared");
      check_quiet(SPC + 4, "rst_gap_end");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single_write();
      test_bank1();
      test_status_read();
      test_back_to_back();
      test_burst_overflow();
      test_reset_in_gap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
